// File: rtl/periph_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : periph_rr_arb
//  Purpose  : Round-robin arbiter that funnels N_CH requester channels onto
//             one peripheral slave port. Request and response paths are
//             purely combinational. An in-order tracker FIFO records which
//             channel owns each outstanding transaction so that each slave
//             response can be routed back to its channel.
//
//  Ports    : clk, rst_n               clock / async active-low reset
//             req_i, add_i, wen_i,     per-channel request and payload,
//             atop_i, wdata_i, be_i    packed channel-major
//             gnt_o, r_valid_o         per-channel grant / response valid
//             r_rdata_o                response data (shared by all channels)
//             req_o .. be_o, gnt_i     slave-side request handshake
//             r_valid_i, r_rdata_i     slave response, in request order
//             err_o                    sticky: response with nothing pending
//
//  Notes    : MAX_OUTST must be a power of two and at least 2.
//  Revision : 1.0 - initial release
// ============================================================================
module periph_rr_arb #(
    parameter int N_CH       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    // requester side
    input  logic [N_CH-1:0]                  req_i,
    input  logic [N_CH*ADDR_WIDTH-1:0]       add_i,
    input  logic [N_CH-1:0]                  wen_i,
    input  logic [N_CH*6-1:0]                atop_i,
    input  logic [N_CH*DATA_WIDTH-1:0]       wdata_i,
    input  logic [N_CH*(DATA_WIDTH/8)-1:0]   be_i,
    output logic [N_CH-1:0]                  gnt_o,
    output logic [N_CH-1:0]                  r_valid_o,
    output logic [DATA_WIDTH-1:0]            r_rdata_o,
    // slave side
    output logic                             req_o,
    output logic [ADDR_WIDTH-1:0]            add_o,
    output logic                             wen_o,
    output logic [5:0]                       atop_o,
    output logic [DATA_WIDTH-1:0]            wdata_o,
    output logic [(DATA_WIDTH/8)-1:0]        be_o,
    input  logic                             gnt_i,
    input  logic                             r_valid_i,
    input  logic [DATA_WIDTH-1:0]            r_rdata_i,
    // status
    output logic                             err_o
);

    localparam int c_BE_WIDTH = DATA_WIDTH / 8;
    localparam int c_IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    // scan sum needs one extra bit: rr_ptr + offset can reach 2*N_CH-2
    localparam int c_SUM_W    = c_IDX_W + 1;
    localparam int c_AW       = $clog2(MAX_OUTST);
    localparam int c_PW       = c_AW + 1;
    localparam logic [N_CH-1:0] c_ONE = {{(N_CH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Unpack the flattened per-channel payload buses
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_add   [N_CH];
    logic [5:0]            w_atop  [N_CH];
    logic [DATA_WIDTH-1:0] w_wdata [N_CH];
    logic [c_BE_WIDTH-1:0] w_be    [N_CH];

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_unpack
            assign w_add[g]   = add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_atop[g]  = atop_i[g*6 +: 6];
            assign w_wdata[g] = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
            assign w_be[g]    = be_i[g*c_BE_WIDTH +: c_BE_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_PW-1:0]    r_wr_ptr;
    logic [c_PW-1:0]    r_rd_ptr;
    logic [c_IDX_W-1:0] r_fifo [MAX_OUTST];
    logic               r_err;

    // ------------------------------------------------------------------
    // Winner selection: first asserted request at or above r_rr_ptr,
    // wrapping to channel 0. With no request the winner stays at r_rr_ptr
    // so the slave payload is deterministic.
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_winner;
    logic [c_IDX_W-1:0] w_rr_next;
    logic [c_SUM_W-1:0] w_scan;
    logic               w_found;

    always_comb begin
        w_winner = r_rr_ptr;
        w_found  = 1'b0;
        w_scan   = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_scan = {1'b0, r_rr_ptr} + c_SUM_W'(i);
            if (w_scan >= c_SUM_W'(N_CH)) begin
                w_scan = w_scan - c_SUM_W'(N_CH);
            end
            if (!w_found && req_i[w_scan[c_IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_scan[c_IDX_W-1:0];
            end
        end
    end

    assign w_rr_next = (w_winner == c_IDX_W'(N_CH - 1)) ? '0
                                                        : w_winner + c_IDX_W'(1);

    // ------------------------------------------------------------------
    // Outstanding tracker status (extra MSB distinguishes full from empty)
    // ------------------------------------------------------------------
    logic               w_full;
    logic               w_empty;
    logic [c_IDX_W-1:0] w_head;

    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_head  = r_fifo[r_rd_ptr[c_AW-1:0]];

    // ------------------------------------------------------------------
    // Handshakes. rst_n gates the outputs directly so nothing is granted
    // or returned while reset is held. req_o uses the registered full
    // flag, so a pop in a full cycle frees a slot only for the next one.
    // ------------------------------------------------------------------
    logic w_push;
    logic w_pop;

    assign req_o  = rst_n & (|req_i) & ~w_full;
    assign w_push = req_o & gnt_i;
    assign w_pop  = rst_n & r_valid_i & ~w_empty;

    assign gnt_o     = w_push ? (c_ONE << w_winner) : '0;
    assign r_valid_o = w_pop  ? (c_ONE << w_head)   : '0;
    assign r_rdata_o = r_rdata_i;

    // slave payload follows the current winner
    assign add_o   = w_add[w_winner];
    assign wen_o   = wen_i[w_winner];
    assign atop_o  = w_atop[w_winner];
    assign wdata_o = w_wdata[w_winner];
    assign be_o    = w_be[w_winner];

    assign err_o = r_err;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= w_rr_next;
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            // a response with nothing outstanding is a protocol violation
            if (r_valid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // Tracker storage needs no reset: entries are only read when valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_AW-1:0]] <= w_winner;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_periph_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_periph_rr_arb
//  Purpose  : Directed self-checking bench for periph_rr_arb (N_CH=4,
//             32-bit address/data, MAX_OUTST=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_periph_rr_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_i;
    logic [127:0] add_i;
    logic [3:0]   wen_i;
    logic [23:0]  atop_i;
    logic [127:0] wdata_i;
    logic [15:0]  be_i;
    logic [3:0]   gnt_o;
    logic [3:0]   r_valid_o;
    logic [31:0]  r_rdata_o;
    logic         req_o;
    logic [31:0]  add_o;
    logic         wen_o;
    logic [5:0]   atop_o;
    logic [31:0]  wdata_o;
    logic [3:0]   be_o;
    logic         gnt_i;
    logic         r_valid_i;
    logic [31:0]  r_rdata_i;
    logic         err_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    periph_rr_arb #(
        .N_CH       (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_OUTST  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .add_i     (add_i),
        .wen_i     (wen_i),
        .atop_i    (atop_i),
        .wdata_i   (wdata_i),
        .be_i      (be_i),
        .gnt_o     (gnt_o),
        .r_valid_o (r_valid_o),
        .r_rdata_o (r_rdata_o),
        .req_o     (req_o),
        .add_o     (add_o),
        .wen_o     (wen_o),
        .atop_o    (atop_o),
        .wdata_o   (wdata_o),
        .be_o      (be_o),
        .gnt_i     (gnt_i),
        .r_valid_i (r_valid_i),
        .r_rdata_i (r_rdata_i),
        .err_o     (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // channel k: addr A000_000k, data D000_000k, wen k%2, atop k+8, be k+1
        for (int k = 0; k < 4; k++) begin
            add_i[k*32 +: 32]   = 32'hA000_0000 + 32'(k);
            wdata_i[k*32 +: 32] = 32'hD000_0000 + 32'(k);
            wen_i[k]            = 1'(k % 2);
            atop_i[k*6 +: 6]    = 6'(k + 8);
            be_i[k*4 +: 4]      = 4'(k + 1);
        end

        // ---- reset: outputs quiet even with requests/responses present
        rst_n     = 1'b0;
        req_i     = 4'b1111;
        gnt_i     = 1'b1;
        r_valid_i = 1'b1;
        r_rdata_i = 32'h0;
        @(posedge clk);
        #2;
        chk("rst_req_o",     64'(req_o),     64'd0);
        chk("rst_gnt_o",     64'(gnt_o),     64'd0);
        chk("rst_r_valid_o", 64'(r_valid_o), 64'd0);
        chk("rst_err_o",     64'(err_o),     64'd0);
        req_i     = 4'b0000;
        gnt_i     = 1'b0;
        r_valid_i = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        chk("rst_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);

        // ---- all channels request: rotate 0,1,2,3 with matching payload
        for (int k = 0; k < 4; k++) begin
            req_i = 4'b1111;
            gnt_i = 1'b1;
            #2;
            chk("rot_gnt",   64'(gnt_o),   64'(4'b0001 << k));
            chk("rot_add",   64'(add_o),   64'(32'hA000_0000 + 32'(k)));
            chk("rot_wdata", 64'(wdata_o), 64'(32'hD000_0000 + 32'(k)));
            chk("rot_wen",   64'(wen_o),   64'(k % 2));
            chk("rot_atop",  64'(atop_o),  64'(k + 8));
            chk("rot_be",    64'(be_o),    64'(k + 1));
            tick();
        end
        chk("rot_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);

        // ---- tracker full: no request; pop in the same cycle still blocks
        req_i     = 4'b1111;
        gnt_i     = 1'b1;
        r_valid_i = 1'b1;
        r_rdata_i = 32'h1111_0000;
        #2;
        chk("full_req_o",   64'(req_o),     64'd0);
        chk("full_gnt_o",   64'(gnt_o),     64'd0);
        chk("full_rvalid",  64'(r_valid_o), 64'b0001);
        chk("full_rdata",   64'(r_rdata_o), 64'h1111_0000);
        tick();
        r_valid_i = 1'b0;
        gnt_i     = 1'b0;
        #2;
        chk("unfull_req_o", 64'(req_o), 64'd1);
        chk("unfull_gnt_o", 64'(gnt_o), 64'd0);
        tick();
        req_i = 4'b0000;
        for (int k = 1; k < 4; k++) begin
            r_valid_i = 1'b1;
            r_rdata_i = 32'h1111_0000 + 32'(k);
            #2;
            chk("drain_rvalid", 64'(r_valid_o), 64'(4'b0001 << k));
            chk("drain_rdata",  64'(r_rdata_o), 64'(32'h1111_0000 + 32'(k)));
            tick();
        end
        r_valid_i = 1'b0;

        // ---- stall with rr_ptr=1, req 0101
        req_i = 4'b0001;
        gnt_i = 1'b1;
        #2;
        chk("pre_gnt", 64'(gnt_o), 64'b0001);
        tick();
        chk("pre_rr_ptr", 64'(dut.r_rr_ptr), 64'd1);
        req_i = 4'b0101;
        gnt_i = 1'b0;
        #2;
        chk("stall_gnt",   64'(gnt_o), 64'd0);
        chk("stall_req_o", 64'(req_o), 64'd1);
        chk("stall_add",   64'(add_o), 64'hA000_0002);
        tick();
        chk("stall_rr_ptr", 64'(dut.r_rr_ptr), 64'd1);
        gnt_i = 1'b1;
        #2;
        chk("unstall_gnt", 64'(gnt_o), 64'b0100);
        tick();
        chk("unstall_rr_ptr", 64'(dut.r_rr_ptr), 64'd3);
        req_i     = 4'b0000;
        gnt_i     = 1'b0;
        r_valid_i = 1'b1;
        r_rdata_i = 32'h2222_0000;
        #2;
        chk("st_resp0", 64'(r_valid_o), 64'b0001);
        tick();
        r_rdata_i = 32'h2222_0001;
        #2;
        chk("st_resp1", 64'(r_valid_o), 64'b0100);
        tick();
        r_valid_i = 1'b0;

        // ---- grants ch2, ch0, ch3 then in-order responses A,B,C
        gnt_i = 1'b1;
        req_i = 4'b0100; #2; chk("ord_gnt2", 64'(gnt_o), 64'b0100); tick();
        req_i = 4'b0001; #2; chk("ord_gnt0", 64'(gnt_o), 64'b0001); tick();
        req_i = 4'b1000; #2; chk("ord_gnt3", 64'(gnt_o), 64'b1000); tick();
        // response A together with a new grant (push+pop same cycle)
        req_i     = 4'b0010;
        r_valid_i = 1'b1;
        r_rdata_i = 32'hAAAA_AAAA;
        #2;
        chk("ord_rvA",  64'(r_valid_o), 64'b0100);
        chk("ord_dA",   64'(r_rdata_o), 64'hAAAA_AAAA);
        chk("ord_gnt1", 64'(gnt_o),     64'b0010);
        tick();
        req_i     = 4'b0000;
        gnt_i     = 1'b0;
        r_rdata_i = 32'hBBBB_BBBB;
        #2;
        chk("ord_rvB", 64'(r_valid_o), 64'b0001);
        chk("ord_dB",  64'(r_rdata_o), 64'hBBBB_BBBB);
        tick();
        r_rdata_i = 32'hCCCC_CCCC;
        #2;
        chk("ord_rvC", 64'(r_valid_o), 64'b1000);
        chk("ord_dC",  64'(r_rdata_o), 64'hCCCC_CCCC);
        tick();
        r_rdata_i = 32'hDDDD_DDDD;
        #2;
        chk("ord_rvD", 64'(r_valid_o), 64'b0010);
        tick();
        r_valid_i = 1'b0;

        // ---- idle payload follows rr_ptr (now 2)
        #2;
        chk("idle_req_o", 64'(req_o), 64'd0);
        chk("idle_add",   64'(add_o), 64'hA000_0002);
        tick();

        // ---- response with empty tracker -> sticky error
        r_valid_i = 1'b1;
        r_rdata_i = 32'h5;
        #2;
        chk("err_rvalid", 64'(r_valid_o), 64'd0);
        chk("err_pre",    64'(err_o),     64'd0);
        tick();
        r_valid_i = 1'b0;
        #2;
        chk("err_set", 64'(err_o), 64'd1);
        tick();
        tick();
        chk("err_hold", 64'(err_o), 64'd1);

        // ---- two outstanding (ch2, ch3), then reset mid-traffic
        req_i = 4'b1111;
        gnt_i = 1'b1;
        #2; chk("mid_gnt2", 64'(gnt_o), 64'b0100); tick();
        #2; chk("mid_gnt3", 64'(gnt_o), 64'b1000); tick();
        req_i     = 4'b1010;
        r_valid_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_o",  64'(req_o),          64'd0);
        chk("mid_rst_gnt_o",  64'(gnt_o),          64'd0);
        chk("mid_rst_rvalid", 64'(r_valid_o),      64'd0);
        chk("mid_rst_err",    64'(err_o),          64'd0);
        chk("mid_rst_rr_ptr", 64'(dut.r_rr_ptr),   64'd0);
        #1;
        rst_n     = 1'b1;
        r_valid_i = 1'b0;
        #1;
        chk("post_rst_gnt",   64'(gnt_o),   64'b0010);
        chk("post_rst_req_o", 64'(req_o),   64'd1);
        chk("post_rst_add",   64'(add_o),   64'hA000_0001);
        chk("post_rst_wen",   64'(wen_o),   64'd1);
        chk("post_rst_atop",  64'(atop_o),  64'd9);
        chk("post_rst_be",    64'(be_o),    64'd2);
        chk("post_rst_wdata", 64'(wdata_o), 64'hD000_0001);
        chk("post_rst_err",   64'(err_o),   64'd0);
        tick();
        chk("post_rst_rr_ptr", 64'(dut.r_rr_ptr), 64'd2);
        req_i = 4'b0000;
        gnt_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
